// File: rtl/regfile_ctrl.sv
// Command-driven controller for a 4x16-bit register file.
// Optional write-verify pass enabled by REGFILE_CTRL_VERIFY_EN.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00 read, 01 write, 10 clear-all, 11 reserved
//   cmd_addr, cmd_wdata   command word index and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    response data and error flag
//   rf_en, rf_wsel, rf_d  register-file write port
//   rf_rsel, rf_q         register-file read port
module regfile_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rf_en,
  output logic [1:0]  rf_wsel,
  output logic [15:0] rf_d,
  output logic [1:0]  rf_rsel,
  input  logic [15:0] rf_q
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    CLEAR  = 3'd3,
    RESP   = 3'd4
`ifdef REGFILE_CTRL_VERIFY_EN
    ,
    VERIFY = 3'd5
`endif
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       rdy_q;
  logic       en_q;

  // rf_wsel and rf_d keep the write address and data after WRITE,
  // so they double as the latched command fields for the response.
  assign cmd_ready = rdy_q & ~rst;
  assign rf_en     = en_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rdy_q     <= 1'b1;
      en_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
      rf_wsel   <= 2'd0;
      rf_d      <= 16'h0000;
      rf_rsel   <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && rdy_q) begin
            rdy_q <= 1'b0;
            unique case (cmd_op)
              2'b00: begin
                state   <= READ;
                rf_rsel <= cmd_addr;
              end
              2'b01: begin
                state   <= WRITE;
                en_q    <= 1'b1;
                rf_wsel <= cmd_addr;
                rf_d    <= cmd_wdata;
              end
              2'b10: begin
                state   <= CLEAR;
                en_q    <= 1'b1;
                rf_wsel <= 2'd0;
                rf_d    <= 16'h0000;
                cnt     <= 2'd0;
              end
              default: begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= 16'h0000;
              end
            endcase
          end
        end
        WRITE: begin
          en_q      <= 1'b0;
          rsp_rdata <= rf_d;
          rsp_err   <= 1'b0;
`ifdef REGFILE_CTRL_VERIFY_EN
          state     <= VERIFY;
          rf_rsel   <= rf_wsel;
`else
          state     <= RESP;
          rsp_valid <= 1'b1;
`endif
        end
`ifdef REGFILE_CTRL_VERIFY_EN
        VERIFY: begin
          rsp_rdata <= rf_q;
          rsp_err   <= (rf_q != rf_d);
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
`endif
        READ: begin
          rsp_rdata <= rf_q;
          rsp_err   <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        CLEAR: begin
          if (cnt == 2'd3) begin
            en_q      <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt     <= cnt + 2'd1;
            rf_wsel <= cnt + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rdy_q     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl with a 4x16 register
// file model attached to the rf_* pins.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rf_en;
  logic [1:0]  rf_wsel;
  logic [15:0] rf_d;
  logic [1:0]  rf_rsel;
  logic [15:0] rf_q;

`ifdef REGFILE_CTRL_VERIFY_EN
  localparam int WLAT = 3;
`else
  localparam int WLAT = 2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mem [4];
  logic        force_zero = 1'b0;
  logic [17:0] en_log [$];

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rf_en     (rf_en),
    .rf_wsel   (rf_wsel),
    .rf_d      (rf_d),
    .rf_rsel   (rf_rsel),
    .rf_q      (rf_q)
  );

  // Register file model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 16'h0000;
    end else if (rf_en) begin
      mem[rf_wsel] <= rf_d;
    end
  end

  assign rf_q = force_zero ? 16'h0000 : mem[rf_rsel];

  // Record every write-enable cycle as {wsel, d}.
  always @(negedge clk) begin
    if (rf_en) en_log.push_back({rf_wsel, rf_d});
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge with the controller idle.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic er, output int lat);
    int k;
    en_log.delete();
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accept", 32'(k < 20), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat;
  logic        stable;
  logic        seen;
  logic [15:0] pat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 2'd0;
    cmd_wdata = 16'h0000;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("rst_rf_en", 32'(rf_en), 32'd0);
    check("rst_rf_wsel", 32'(rf_wsel), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    do_cmd(2'b01, 2'd2, 16'hBEEF, rd, er, lat);
    check("wr_beef_data", 32'(rd), 32'hBEEF);
    check("wr_beef_err", 32'(er), 32'd0);
    check("wr_beef_lat", 32'(lat), 32'(WLAT));
    check("wr_beef_npulse", 32'(en_log.size()), 32'd1);
    if (en_log.size() > 0)
      check("wr_beef_pulse", 32'(en_log[0]), {14'd0, 2'd2, 16'hBEEF});
    do_cmd(2'b00, 2'd2, 16'h0000, rd, er, lat);
    check("rd_beef_data", 32'(rd), 32'hBEEF);
    check("rd_beef_lat", 32'(lat), 32'd2);

    for (int i = 0; i < 4; i++) begin
      pat = 16'(16'h1111 * (i + 1));
      do_cmd(2'b01, 2'(i), pat, rd, er, lat);
      check("fill_data", 32'(rd), 32'(pat));
      check("fill_err", 32'(er), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      pat = 16'(16'h1111 * (i + 1));
      do_cmd(2'b00, 2'(i), 16'h0000, rd, er, lat);
      check("fill_rd_data", 32'(rd), 32'(pat));
      check("fill_rd_err", 32'(er), 32'd0);
    end

    // Response stall with a competing write offered meanwhile.
    en_log.delete();
    rsp_ready = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 2'd1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op    = 2'b01;
    cmd_wdata = 16'hDEAD;
    @(negedge clk);
    stable = 1'b1;
    repeat (10) begin
      if (!(rsp_valid && rsp_rdata == 16'h2222 && !rsp_err && !cmd_ready))
        stable = 1'b0;
      @(negedge clk);
    end
    check("stall_stable", 32'(stable), 32'd1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_done_valid", 32'(rsp_valid), 32'd0);
    check("stall_no_write", 32'(en_log.size()), 32'd0);
    do_cmd(2'b00, 2'd1, 16'h0000, rd, er, lat);
    check("stall_rd_after", 32'(rd), 32'h2222);

    do_cmd(2'b10, 2'd0, 16'h0000, rd, er, lat);
    check("clr_lat", 32'(lat), 32'd5);
    check("clr_data", 32'(rd), 32'h0);
    check("clr_err", 32'(er), 32'd0);
    check("clr_npulse", 32'(en_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < en_log.size())
        check("clr_pulse", 32'(en_log[i]), {14'd0, 2'(i), 16'h0000});
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(2'b00, 2'(i), 16'h0000, rd, er, lat);
      check("clr_rd_zero", 32'(rd), 32'h0);
    end

    do_cmd(2'b11, 2'd1, 16'h1234, rd, er, lat);
    check("rsv_lat", 32'(lat), 32'd1);
    check("rsv_err", 32'(er), 32'd1);
    check("rsv_data", 32'(rd), 32'h0);
    check("rsv_npulse", 32'(en_log.size()), 32'd0);

    // Reset in the second CLEAR cycle.
    en_log.delete();
    cmd_op    = 2'b10;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rstmid_en_gated", 32'(rf_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstmid_npulse", 32'(en_log.size()), 32'd1);
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_wsel", 32'(rf_wsel), 32'd0);
    check("rstmid_rsel", 32'(rf_rsel), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rstmid_no_rsp", 32'(seen), 32'd0);
    do_cmd(2'b01, 2'd3, 16'h5A5A, rd, er, lat);
    check("rstmid_wr_next", 32'(rd), 32'h5A5A);
    do_cmd(2'b00, 2'd3, 16'h0000, rd, er, lat);
    check("rstmid_rd_next", 32'(rd), 32'h5A5A);

`ifdef REGFILE_CTRL_VERIFY_EN
    force_zero = 1'b1;
    do_cmd(2'b01, 2'd0, 16'h00FF, rd, er, lat);
    force_zero = 1'b0;
    check("vfy_err", 32'(er), 32'd1);
    check("vfy_data", 32'(rd), 32'h0);
    do_cmd(2'b01, 2'd0, 16'h00FF, rd, er, lat);
    check("vfy_ok_err", 32'(er), 32'd0);
    check("vfy_ok_lat", 32'(lat), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
